// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences load/store requests from the MEM stage onto a word-wide,
// big-endian data RAM (combinational read, posedge write).
// Sub-word stores are performed as read-modify-write. Misaligned or out-of-range
// requests are answered with an error and never touch the RAM.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (ready only while idle)
//   i_req_op                 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH
//   i_req_addr, i_req_wdata  byte address and store data
//   o_rsp_valid/data/err     one-cycle completion pulse, load result, error flag
//   o_ram_ce/we/addr/wdata   RAM controls, word-aligned address and write word
//   i_ram_rdata              combinational RAM read data
module mem_access_unit #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_LIMIT = 2048
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [2:0]        i_req_op,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rsp_err,
   output logic              o_ram_ce,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b010;
   localparam logic [2:0] OP_LH  = 3'b011;
   localparam logic [2:0] OP_LHU = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b110;
   localparam logic [2:0] OP_SH  = 3'b111;

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_t;

   state_t            r_state;
   logic [2:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_merge;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;

   logic              w_misaligned;
   logic              w_out_of_range;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_load;
   logic [DATA_W-1:0] w_merge;

   // Request checks use the live request so an error can be answered on the next edge.
   always_comb begin
      w_misaligned = 1'b0;
      case (i_req_op)
         OP_LH, OP_LHU, OP_SH: w_misaligned = i_req_addr[0];
         OP_LW, OP_SW:         w_misaligned = |i_req_addr[1:0];
         default:              w_misaligned = 1'b0;
      endcase
   end

   assign w_out_of_range = (i_req_addr >= ADDR_W'(ADDR_LIMIT));

   // Big-endian lanes: byte offset 0 lives in bits [31:24].
   always_comb begin
      w_byte = 8'h00;
      unique case (r_addr[1:0])
         2'd0: w_byte = i_ram_rdata[31:24];
         2'd1: w_byte = i_ram_rdata[23:16];
         2'd2: w_byte = i_ram_rdata[15:8];
         2'd3: w_byte = i_ram_rdata[7:0];
      endcase
      w_half = r_addr[1] ? i_ram_rdata[15:0] : i_ram_rdata[31:16];

      w_load = i_ram_rdata;
      case (r_op)
         OP_LB:   w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
         OP_LBU:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
         OP_LH:   w_load = {{(DATA_W-16){w_half[15]}}, w_half};
         OP_LHU:  w_load = {{(DATA_W-16){1'b0}}, w_half};
         default: w_load = i_ram_rdata;
      endcase

      w_merge = i_ram_rdata;
      if (r_op == OP_SB) begin
         unique case (r_addr[1:0])
            2'd0: w_merge[31:24] = r_wdata[7:0];
            2'd1: w_merge[23:16] = r_wdata[7:0];
            2'd2: w_merge[15:8]  = r_wdata[7:0];
            2'd3: w_merge[7:0]   = r_wdata[7:0];
         endcase
      end else if (r_addr[1]) begin
         w_merge[15:0] = r_wdata[15:0];
      end else begin
         w_merge[31:16] = r_wdata[15:0];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_op        <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_merge     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_req_valid) begin
                  r_op    <= i_req_op;
                  r_addr  <= i_req_addr;
                  r_wdata <= i_req_wdata;
                  if (w_misaligned || w_out_of_range) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_data  <= '0;
                  end else if (i_req_op == OP_SW) begin
                     r_state <= StWrite;
                  end else begin
                     r_state <= StRead;
                  end
               end
            end
            StRead: begin
               if (r_op == OP_SB || r_op == OP_SH) begin
                  r_merge <= w_merge;
                  r_state <= StWrite;
               end else begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= w_load;
                  r_state     <= StIdle;
               end
            end
            StWrite: begin
               r_rsp_valid <= 1'b1;
               r_rsp_data  <= '0;
               r_state     <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_req_ready = (r_state == StIdle);
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_err   = r_rsp_err;
   assign o_ram_ce    = (r_state != StIdle);
   assign o_ram_we    = (r_state == StWrite);
   assign o_ram_addr  = {r_addr[ADDR_W-1:2], 2'b00};
   assign o_ram_wdata = (r_state != StWrite) ? '0 : (r_op == OP_SW) ? r_wdata : r_merge;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide RAM model covering bytes 0..2047.
module tb_mem_access_unit;

   localparam logic [2:0] LW = 3'b000, LB = 3'b001, LBU = 3'b010, LH = 3'b011;
   localparam logic [2:0] LHU = 3'b100, SW = 3'b101, SB = 3'b110, SH = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        ram_ce;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] mem [0:511];
   logic        mem_clr = 1'b1;
   int unsigned ce_cnt = 0;

   int n_checks = 0;
   int n_pass   = 0;

   mem_access_unit #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .ADDR_LIMIT(2048)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req_valid(req_valid),
      .o_req_ready(req_ready),
      .i_req_op   (req_op),
      .i_req_addr (req_addr),
      .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid),
      .o_rsp_data (rsp_data),
      .o_rsp_err  (rsp_err),
      .o_ram_ce   (ram_ce),
      .o_ram_we   (ram_we),
      .o_ram_addr (ram_addr),
      .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   assign ram_rdata = mem[ram_addr[10:2]];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 512; i++) mem[i] <= '0;
      end else if (ram_ce && ram_we) begin
         mem[ram_addr[10:2]] <= ram_wdata;
      end
      if (ram_ce) ce_cnt <= ce_cnt + 1;
   end

   // Issue one request and measure cycles from the accept edge to rsp_valid (10 = timeout).
   task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output logic err);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      data = rsp_data;
      err  = rsp_err;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else n_pass++;
      n_checks++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data got %h want 0", rsp_data); else n_pass++;
      n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", rsp_err); else n_pass++;
      n_checks++; if ({ram_ce, ram_we} !== 2'b00) $display("FAIL reset_ce_we got %b want 00", {ram_ce, ram_we}); else n_pass++;
      n_checks++; if (ram_addr !== 32'h0) $display("FAIL reset_ram_addr got %h want 0", ram_addr); else n_pass++;
      n_checks++; if (ram_wdata !== 32'h0) $display("FAIL reset_ram_wdata got %h want 0", ram_wdata); else n_pass++;
      n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      mem_clr = 1'b0;
   endtask

   task automatic test_word();
      int lat; logic [31:0] d; logic e;
      do_req(SW, 32'h10, 32'h11223344, lat, d, e);
      n_checks++; if (lat !== 2 || e !== 1'b0 || d !== 32'h0) $display("FAIL sw_rsp got lat=%0d err=%b data=%h want lat=2 err=0 data=0", lat, e, d); else n_pass++;
      n_checks++; if (mem[4] !== 32'h11223344) $display("FAIL sw_ram got %h want 11223344", mem[4]); else n_pass++;
      do_req(LW, 32'h10, 32'h0, lat, d, e);
      n_checks++; if (lat !== 2 || e !== 1'b0 || d !== 32'h11223344) $display("FAIL lw_rsp got lat=%0d err=%b data=%h want lat=2 err=0 data=11223344", lat, e, d); else n_pass++;
   endtask

   task automatic test_loads();
      int lat; logic [31:0] d; logic e;
      do_req(LB, 32'h13, 32'h0, lat, d, e);
      n_checks++; if (lat !== 2 || d !== 32'h00000044) $display("FAIL lb_13 got lat=%0d data=%h want lat=2 data=00000044", lat, d); else n_pass++;
      do_req(LBU, 32'h11, 32'h0, lat, d, e);
      n_checks++; if (d !== 32'h00000022) $display("FAIL lbu_11 got %h want 00000022", d); else n_pass++;
      do_req(LH, 32'h12, 32'h0, lat, d, e);
      n_checks++; if (lat !== 2 || d !== 32'h00003344) $display("FAIL lh_12 got lat=%0d data=%h want lat=2 data=00003344", lat, d); else n_pass++;
      do_req(SB, 32'h10, 32'h00000080, lat, d, e);
      n_checks++; if (mem[4] !== 32'h80223344) $display("FAIL sb_10_ram got %h want 80223344", mem[4]); else n_pass++;
      do_req(LB, 32'h10, 32'h0, lat, d, e);
      n_checks++; if (d !== 32'hFFFFFF80) $display("FAIL lb_10_sext got %h want ffffff80", d); else n_pass++;
      do_req(LBU, 32'h10, 32'h0, lat, d, e);
      n_checks++; if (d !== 32'h00000080) $display("FAIL lbu_10_zext got %h want 00000080", d); else n_pass++;
      do_req(LH, 32'h10, 32'h0, lat, d, e);
      n_checks++; if (d !== 32'hFFFF8022) $display("FAIL lh_10_sext got %h want ffff8022", d); else n_pass++;
      do_req(LHU, 32'h10, 32'h0, lat, d, e);
      n_checks++; if (lat !== 2 || d !== 32'h00008022) $display("FAIL lhu_10_zext got lat=%0d data=%h want lat=2 data=00008022", lat, d); else n_pass++;
   endtask

   task automatic test_subword_store();
      int lat; logic [31:0] d; logic e;
      do_req(SW, 32'h10, 32'h11223344, lat, d, e);
      do_req(SB, 32'h11, 32'hFFFFFFAA, lat, d, e);
      n_checks++; if (lat !== 3 || e !== 1'b0 || d !== 32'h0) $display("FAIL sb_11_rsp got lat=%0d err=%b data=%h want lat=3 err=0 data=0", lat, e, d); else n_pass++;
      n_checks++; if (mem[4] !== 32'h11AA3344) $display("FAIL sb_11_ram got %h want 11aa3344", mem[4]); else n_pass++;
      do_req(SH, 32'h12, 32'h5555BEEF, lat, d, e);
      n_checks++; if (lat !== 3 || mem[4] !== 32'h11AABEEF) $display("FAIL sh_12 got lat=%0d ram=%h want lat=3 ram=11aabeef", lat, mem[4]); else n_pass++;
      do_req(SB, 32'h23, 32'h0000005A, lat, d, e);
      n_checks++; if (mem[8] !== 32'h0000005A) $display("FAIL sb_23_ram got %h want 0000005a", mem[8]); else n_pass++;
      do_req(SH, 32'h20, 32'h00001234, lat, d, e);
      n_checks++; if (mem[8] !== 32'h1234005A) $display("FAIL sh_20_ram got %h want 1234005a", mem[8]); else n_pass++;
   endtask

   task automatic test_errors();
      int lat; logic [31:0] d; logic e;
      int unsigned ce0;
      logic [31:0] w4;
      ce0 = ce_cnt;
      w4  = mem[4];
      do_req(LW, 32'h2, 32'h0, lat, d, e);
      n_checks++; if (lat !== 1 || e !== 1'b1 || d !== 32'h0) $display("FAIL err_lw_2 got lat=%0d err=%b data=%h want lat=1 err=1 data=0", lat, e, d); else n_pass++;
      do_req(SH, 32'h11, 32'hFFFF, lat, d, e);
      n_checks++; if (lat !== 1 || e !== 1'b1 || d !== 32'h0) $display("FAIL err_sh_11 got lat=%0d err=%b data=%h want lat=1 err=1 data=0", lat, e, d); else n_pass++;
      do_req(LW, 32'h800, 32'h0, lat, d, e);
      n_checks++; if (lat !== 1 || e !== 1'b1 || d !== 32'h0) $display("FAIL err_lw_800 got lat=%0d err=%b data=%h want lat=1 err=1 data=0", lat, e, d); else n_pass++;
      @(posedge clk);
      #1;
      n_checks++; if (ce_cnt !== ce0) $display("FAIL err_no_ce got %0d ce cycles want 0", ce_cnt - ce0); else n_pass++;
      n_checks++; if (mem[4] !== w4) $display("FAIL err_ram_kept got %h want %h", mem[4], w4); else n_pass++;
      do_req(SW, 32'h7FC, 32'hA5A5A5A5, lat, d, e);
      do_req(LW, 32'h7FC, 32'h0, lat, d, e);
      n_checks++; if (lat !== 2 || e !== 1'b0 || d !== 32'hA5A5A5A5) $display("FAIL io_top_lw got lat=%0d err=%b data=%h want lat=2 err=0 data=a5a5a5a5", lat, e, d); else n_pass++;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = SW;
      req_addr  = 32'h30;
      req_wdata = 32'hCAFEF00D;
      @(posedge clk);               // SW accepted
      #1;
      req_op    = LW;               // ignored while busy
      req_wdata = 32'h0;
      @(posedge clk);               // SW commits, response pulses
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1) $display("FAIL b2b_sw_rsp got valid=%b ready=%b want 1 1", rsp_valid, req_ready); else n_pass++;
      @(posedge clk);               // LW accepted in the response cycle
      #1;
      req_valid = 1'b0;
      n_checks++; if (rsp_valid !== 1'b0 || ram_ce !== 1'b1 || ram_we !== 1'b0) $display("FAIL b2b_lw_accept got valid=%b ce=%b we=%b want 0 1 0", rsp_valid, ram_ce, ram_we); else n_pass++;
      @(posedge clk);
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFEF00D) $display("FAIL b2b_lw_rsp got valid=%b data=%h want 1 cafef00d", rsp_valid, rsp_data); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int lat; logic [31:0] d; logic e;
      logic seen;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = SB;
      req_addr  = 32'h21;
      req_wdata = 32'h77;
      @(posedge clk);               // accept, READ next
      #1;
      req_valid = 1'b0;
      @(posedge clk);               // merge, WRITE next
      #1;
      n_checks++; if (ram_we !== 1'b1 || ram_wdata !== 32'h1277005A) $display("FAIL abort_write_phase got we=%b wdata=%h want 1 1277005a", ram_we, ram_wdata); else n_pass++;
      #1;
      rst = 1'b1;
      #1;
      n_checks++; if ({ram_ce, ram_we, rsp_valid} !== 3'b000 || ram_addr !== 32'h0 || ram_wdata !== 32'h0 || req_ready !== 1'b1)
         $display("FAIL abort_outputs got ce=%b we=%b valid=%b addr=%h wdata=%h ready=%b want 0 0 0 0 0 1",
                  ram_ce, ram_we, rsp_valid, ram_addr, ram_wdata, req_ready);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (rsp_valid) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_rsp got rsp_valid=%b want 0", seen); else n_pass++;
      n_checks++; if (mem[8] !== 32'h1234005A) $display("FAIL abort_ram_kept got %h want 1234005a", mem[8]); else n_pass++;
      do_req(LW, 32'h20, 32'h0, lat, d, e);
      n_checks++; if (lat !== 2 || e !== 1'b0 || d !== 32'h1234005A) $display("FAIL abort_then_lw got lat=%0d err=%b data=%h want lat=2 err=0 data=1234005a", lat, e, d); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_word();
      test_loads();
      test_subword_store();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage access sequencer between the pipeline MEM stage and the word-wide, big-endian data RAM (`ce`/`we`, combinational read, posedge write, word-aligned address).
- Converts LW/LB/LBU/LH/LHU/SW/SB/SH requests into aligned word accesses.
- Sub-word stores become a read-modify-write sequence.
- Flags misaligned and out-of-range requests without touching the RAM.

Parameters:
- ADDR_W, 32, width of request and RAM address.
- DATA_W, 32, data width (fixed at 32; the byte-lane logic assumes 4 lanes).
- ADDR_LIMIT, 2048, first illegal byte address. [0,1023] is RAM, [1024,2047] is the IO window, and both are legal.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_op  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data; SB uses [7:0], SH uses [15:0]
- rsp_valid  output  1  one-cycle completion pulse
- rsp_data  output  DATA_W  load result, sign/zero-extended; 0 for stores and errors
- rsp_err  output  1  valid only with rsp_valid; misaligned or addr >= ADDR_LIMIT
- ram_ce  output  1  RAM chip enable
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_W  word-aligned address {addr_q[ADDR_W-1:2], 2'b00}
- ram_wdata  output  DATA_W  word to write
- ram_rdata  input  DATA_W  combinational read data from RAM

Behaviour:
- Reset (async, immediate): state=IDLE. rsp_valid=0, rsp_data=0, rsp_err=0, op_q/addr_q/wdata_q/merge_q=0.
- Outputs are decoded from registered state only, so ram_ce=0, ram_we=0, ram_addr=0 and ram_wdata=0 while reset is asserted.
- States: IDLE, READ, WRITE.
- IDLE:
  - req_ready=1 and ram_ce=0.
  - On posedge with req_valid=1: latch op, addr and wdata.
  - Misaligned request (LH/LHU/SH with addr[0]!=0, LW/SW with addr[1:0]!=0) or addr >= ADDR_LIMIT: stay IDLE and pulse rsp_valid=1, rsp_err=1, rsp_data=0 next cycle. No RAM access.
  - SW: go to WRITE.
  - All other ops: go to READ.
- READ:
  - req_ready=0, ram_ce=1, ram_we=0.
  - At posedge, loads extract from ram_rdata using big-endian lane order (byte offset 0 = bits [31:24]):
    - LB/LBU: byte = rdata[31-8*addr[1:0] -: 8].
    - LH/LHU: half = addr[1] ? rdata[15:0] : rdata[31:16].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
    - Register rsp_data, pulse rsp_valid (err=0), go IDLE.
  - At posedge, SB/SH set merge_q = rdata with the addressed lane(s) replaced by wdata_q[7:0] or [15:0], then go to WRITE.
- WRITE:
  - req_ready=0, ram_ce=1, ram_we=1.
  - ram_wdata = wdata_q for SW, merge_q for SB/SH.
  - The RAM commits on this posedge. Pulse rsp_valid (rsp_data=0, err=0) and go IDLE.
- rsp_valid is a registered pulse lasting exactly 1 cycle. It coincides with IDLE, so a new request may be accepted in the same cycle the response is seen (back-to-back).
- Latency, counted from the accept edge to rsp_valid high:
  - Error: 1 cycle.
  - LW, LB, LBU, LH, LHU, SW: 2 cycles.
  - SB, SH: 3 cycles.
- req_* inputs are ignored outside IDLE. The caller holds the pipeline on req_ready=0.
- Reset during READ/WRITE aborts with no response.
- If rst asserts before the WRITE posedge, no RAM write occurs.
- An SB/SH aborted after READ leaves the RAM unmodified.

Test Plan:
- SW addr 0x10, data 0x11223344, then LW 0x10 -> RAM bytes 0x10..0x13 = 11,22,33,44; LW rsp_data=0x11223344 at 2 cycles; SW rsp at 2 cycles.
- After the above: LB 0x13 -> 0x00000044; LB 0x10 with byte 0x80 stored -> 0xFFFFFF80; LBU same -> 0x00000080; LH 0x12 -> 0x00003344.
- SB 0x11 data 0xAA over 0x11223344 -> RAM word 0x11AA3344, rsp at 3 cycles. SH 0x12 data 0xBEEF -> 0x11AABEEF.
- LW 0x0002, SH 0x0001, and LW 0x0800 -> rsp_err=1 at 1 cycle, ram_ce never asserted, RAM contents unchanged.
- Back-to-back: assert req_valid continuously with SW then LW to the same address -> second request accepted in the same cycle as the first rsp_valid; LW returns the new data; no idle bubble beyond the defined latency.
- SB in flight, rst asserted during WRITE before the posedge -> outputs zero immediately, state IDLE, RAM word unchanged, no rsp_valid. A following LW behaves normally.
